adxl362_ctrl: RTL
=================

ADXL362_CTRL -- requirements
Module: adxl362_ctrl

Interface
REQ-001 Parameter SYSCLK_FREQUENCY_HZ, default 108000000, system clock rate.
REQ-002 Parameter SAMPLE_PERIOD_CYC, default 1080000, clk cycles between sample reads (100 Hz).
REQ-003 Parameter PWRUP_CYC, default 540000, post-reset wait before configuration (5 ms).
REQ-004 Parameter GAP_CYC, default 108, minimum cycles with hold_ss low between SPI transactions.
REQ-005 Parameter TIMEOUT_CYC, default 2048, maximum cycles waiting for one byte's done.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 spi_data_in  output  8  byte to transmit; drives the SPI byte engine's data_in.
REQ-009 spi_start  output  1  one-cycle pulse requesting one byte transfer.
REQ-010 spi_hold_ss  output  1  high for the whole multi-byte transaction, keeps SS asserted.
REQ-011 spi_data_out  input  8  byte received by the engine; valid in the cycle spi_done is high.
REQ-012 spi_done  input  1  one-cycle pulse, byte transfer complete.
REQ-013 accel_x, accel_y, accel_z  output  12 each  signed two's-complement axis samples.
REQ-014 data_valid  output  1  one-cycle pulse when all three axes update.
REQ-015 spi_error  output  1  one-cycle pulse on byte timeout.

Function
REQ-016 States: PWRUP, CFG, GAP_CFG, WAIT_SAMPLE, READ, ERR_GAP; advances one state per transition condition.
REQ-017 PWRUP: counts PWRUP_CYC cycles, then enters CFG.
REQ-018 CFG transaction: 3 bytes 0x0A, 0x2D, 0x02 (write POWER_CTL = measurement mode).
REQ-019 READ transaction: 8 bytes 0x0B, 0x0E, then six 0x00 dummies; received bytes 3..8 are XL, XH, YL, YH, ZL, ZH.
REQ-020 Per byte: spi_data_in stable from the spi_start cycle until spi_done; spi_start high exactly one cycle; next spi_start no earlier than the cycle after spi_done.
REQ-021 spi_hold_ss rises with the first byte's spi_start and falls in the cycle after the last byte's spi_done.
REQ-022 Received bytes of the command/address phases are discarded.
REQ-023 After CFG: GAP_CFG holds hold_ss low GAP_CYC cycles, then WAIT_SAMPLE.
REQ-024 WAIT_SAMPLE: free-running period counter wraps at SAMPLE_PERIOD_CYC-1; READ starts on wrap; counter keeps running during READ.
REQ-025 Wrap while READ still active is dropped, not queued.
REQ-026 Axis assembly: value = {H[3:0], L}; H[7:4] ignored.
REQ-027 accel_x/y/z update together in the cycle after ZH's spi_done; data_valid pulses that same cycle; outputs hold between updates.
REQ-028 Partial reads never change accel outputs.
REQ-029 Timeout: byte wait counter reset at each spi_start; reaching TIMEOUT_CYC aborts: spi_error pulses once, hold_ss drops, ERR_GAP waits GAP_CYC, then returns to the aborted transaction's start (CFG if configuration incomplete, else WAIT_SAMPLE).
REQ-030 spi_done outside a byte wait is ignored.
REQ-031 Latency, READ start to data_valid: sum of 8 engine byte times plus 8 controller cycles at most.

Reset
REQ-032 reset: state PWRUP, all counters 0, spi_start 0, spi_hold_ss 0, spi_data_in 0x00, accel_x/y/z 0, data_valid 0, spi_error 0.
REQ-033 reset mid-transaction: hold_ss low the next cycle, transaction abandoned, outputs cleared, full PWRUP and CFG repeated.

Verification (bench uses PWRUP_CYC=10, SAMPLE_PERIOD_CYC=400, GAP_CYC=4, TIMEOUT_CYC=50, SPI engine model answering spi_done 8 cycles after spi_start)
REQ-034 Release reset -> after 10 cycles 3 starts with bytes 0x0A,0x2D,0x02, hold_ss continuous over all three, then hold_ss low >=4 cycles.
REQ-035 Model returns XL..ZH = 0x34,0xF2,0xFF,0x07,0x00,0x08 -> one data_valid; accel_x=0x234, accel_y=0x7FF, accel_z=0x800; sequence 0x0B,0x0E,0x00x6 transmitted.
REQ-036 Two consecutive periods with different data -> exactly two data_valid pulses, 400 cycles apart, outputs stable between them.
REQ-037 Model withholds spi_done on 5th READ byte -> spi_error pulse 50 cycles after that spi_start, hold_ss low, accel outputs unchanged, next period read succeeds.
REQ-038 Reset asserted during 4th READ byte -> next cycle hold_ss=0, accel outputs 0; recovery repeats PWRUP and CFG sequence.
REQ-039 Spurious spi_done in WAIT_SAMPLE -> no state change, no start, no output change.

Source files
------------

// File: rtl/adxl362_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adxl362_ctrl
// Brief    : ADXL362 power-up configuration and periodic XYZ sample readout
//            driven through a byte-wise SPI engine.
// Revision : 1.0 - initial release
// ============================================================================
module adxl362_ctrl #(
  parameter int unsigned SYSCLK_FREQUENCY_HZ = 108000000,
  parameter int unsigned SAMPLE_PERIOD_CYC   = SYSCLK_FREQUENCY_HZ / 100,
  parameter int unsigned PWRUP_CYC           = SYSCLK_FREQUENCY_HZ / 200,
  parameter int unsigned GAP_CYC             = SYSCLK_FREQUENCY_HZ / 1000000,
  parameter int unsigned TIMEOUT_CYC         = 2048
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  spi_data_in,
  output logic        spi_start,
  output logic        spi_hold_ss,
  input  logic [7:0]  spi_data_out,
  input  logic        spi_done,
  output logic [11:0] accel_x,
  output logic [11:0] accel_y,
  output logic [11:0] accel_z,
  output logic        data_valid,
  output logic        spi_error
);

  typedef enum logic [2:0] {
    S_PWRUP       = 3'd0,
    S_CFG         = 3'd1,
    S_GAP_CFG     = 3'd2,
    S_WAIT_SAMPLE = 3'd3,
    S_READ        = 3'd4,
    S_ERR_GAP     = 3'd5
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_cnt, r_period, r_wait;
  logic [2:0]  r_idx, w_issue_idx;
  logic [7:0]  r_data_in, w_issue_byte;
  logic        r_busy, r_cfg_done, r_start, r_hold, r_dv, r_error;
  logic [7:0]  r_xl, r_yl, r_zl;
  logic [3:0]  r_xh, r_yh;
  logic [11:0] r_ax, r_ay, r_az;
  logic        w_byte_done, w_timeout, w_last, w_wrap, w_in_xfer, w_enter, w_issue;

  assign w_in_xfer   = (r_state == S_CFG) || (r_state == S_READ);
  assign w_byte_done = r_busy && spi_done;
  assign w_timeout   = r_busy && !spi_done && (r_wait == TIMEOUT_CYC - 1);
  assign w_last      = (r_state == S_CFG) ? (r_idx == 3'd2) : (r_idx == 3'd7);
  assign w_wrap      = r_cfg_done && (r_period == SAMPLE_PERIOD_CYC - 1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_PWRUP;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PWRUP:       if (r_cnt == PWRUP_CYC - 1) w_state_next = S_CFG;
      S_CFG:         if (w_timeout) w_state_next = S_ERR_GAP;
                     else if (w_byte_done && w_last) w_state_next = S_GAP_CFG;
      S_GAP_CFG:     if (r_cnt == GAP_CYC - 1) w_state_next = S_WAIT_SAMPLE;
      S_WAIT_SAMPLE: if (w_wrap) w_state_next = S_READ;
      S_READ:        if (w_timeout) w_state_next = S_ERR_GAP;
                     else if (w_byte_done && w_last) w_state_next = S_WAIT_SAMPLE;
      S_ERR_GAP:     if (r_cnt == GAP_CYC - 1)
                       w_state_next = r_cfg_done ? S_WAIT_SAMPLE : S_CFG;
      default:       w_state_next = S_PWRUP;
    endcase
  end

  // The first byte is launched on the transition itself; later bytes launch
  // straight off the previous byte's done to keep per-byte overhead at one cycle.
  assign w_enter     = !w_in_xfer && ((w_state_next == S_CFG) || (w_state_next == S_READ));
  assign w_issue     = w_enter || (w_byte_done && !w_last && !w_timeout);
  assign w_issue_idx = w_enter ? 3'd0 : r_idx + 3'd1;

  always_comb begin
    w_issue_byte = 8'h00;
    if (w_state_next == S_CFG) begin
      case (w_issue_idx)
        3'd0:    w_issue_byte = 8'h0A;
        3'd1:    w_issue_byte = 8'h2D;
        default: w_issue_byte = 8'h02;
      endcase
    end else begin
      case (w_issue_idx)
        3'd0:    w_issue_byte = 8'h0B;
        3'd1:    w_issue_byte = 8'h0E;
        default: w_issue_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_period   <= '0;
      r_wait     <= '0;
      r_idx      <= '0;
      r_data_in  <= '0;
      r_busy     <= 1'b0;
      r_cfg_done <= 1'b0;
      r_start    <= 1'b0;
      r_hold     <= 1'b0;
      r_dv       <= 1'b0;
      r_error    <= 1'b0;
      r_xl       <= '0;
      r_xh       <= '0;
      r_yl       <= '0;
      r_yh       <= '0;
      r_zl       <= '0;
      r_ax       <= '0;
      r_ay       <= '0;
      r_az       <= '0;
    end else begin
      r_cnt   <= (w_state_next != r_state) ? 32'd0 : r_cnt + 32'd1;
      r_start <= w_issue;
      r_error <= w_timeout;
      r_dv    <= 1'b0;
      // Period counter free-runs once configured; a wrap seen outside
      // WAIT_SAMPLE is simply lost.
      if (!r_cfg_done || w_wrap) r_period <= '0;
      else                       r_period <= r_period + 32'd1;
      if (r_state == S_CFG && w_state_next == S_GAP_CFG) r_cfg_done <= 1'b1;

      if (w_issue) begin
        r_idx     <= w_issue_idx;
        r_data_in <= w_issue_byte;
        r_busy    <= 1'b1;
        r_hold    <= 1'b1;
        r_wait    <= '0;
      end else begin
        if (r_busy) r_wait <= r_wait + 32'd1;
        if (w_byte_done || w_timeout) r_busy <= 1'b0;
        if ((w_byte_done && w_last) || w_timeout) r_hold <= 1'b0;
      end

      if (w_byte_done && r_state == S_READ) begin
        case (r_idx)
          3'd2: r_xl <= spi_data_out;
          3'd3: r_xh <= spi_data_out[3:0];
          3'd4: r_yl <= spi_data_out;
          3'd5: r_yh <= spi_data_out[3:0];
          3'd6: r_zl <= spi_data_out;
          3'd7: begin
            r_ax <= {r_xh, r_xl};
            r_ay <= {r_yh, r_yl};
            r_az <= {spi_data_out[3:0], r_zl};
            r_dv <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_data_in = r_data_in;
  assign spi_start   = r_start;
  assign spi_hold_ss = r_hold;
  assign accel_x     = r_ax;
  assign accel_y     = r_ay;
  assign accel_z     = r_az;
  assign data_valid  = r_dv;
  assign spi_error   = r_error;

endmodule
`default_nettype wire
